bus_ctrl_pipe: RTL

BUS_CTRL_PIPE -- requirements
Module: bus_ctrl_pipe

---
 rtl/bus_ctrl_pipe.sv | 119 +++++++++++
 1 files changed

// File: rtl/bus_ctrl_pipe.sv
// Microcode sequencer: accepts opcodes, walks {opcode, step} through an external ROM and registers control fields.
// Optional BUS_CTRL_PIPE_STEP_LIMIT_EN forces an instruction end at step 7 and sets a sticky overrun flag.
module bus_ctrl_pipe (
    input  logic        Clock_In,
    input  logic        Reset_In,
    input  logic        Instr_Valid,
    input  logic [7:0]  Instr_Opcode,
    output logic        Instr_Ready,
    output logic [10:0] Rom_Addr,
    input  logic [31:0] Rom_Word,
    input  logic        Stall,
    input  logic        Flush,
    output logic [3:0]  Bus_Assert,
    output logic [3:0]  Bus_Load,
    output logic [2:0]  Xfer_Assert,
    output logic [3:0]  XferLoadDec,
    output logic [1:0]  Inc_PCRA,
    output logic [1:0]  Inc_SPSIDI,
    output logic [1:0]  LHS,
    output logic [1:0]  RHS,
    output logic [2:0]  AddrSel,
    output logic        Ctrl_Valid,
    output logic        Step_Overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    // Control fields occupy Rom_Word[25:0] in output order; NOP parks PC increment and address select.
    localparam logic [25:0] NOP = 26'h381_0000;

    state_t      state;
    logic [7:0]  opcode_reg;
    logic [2:0]  step;
    logic [25:0] ctrl_q;
    logic        vld_q;
    logic        overrun;
    logic        end_eff;
    logic        accept;
    logic        unused_bits;

    assign unused_bits = ^Rom_Word[31:27];

    always_comb begin
        overrun = 1'b0;
`ifdef BUS_CTRL_PIPE_STEP_LIMIT_EN
        overrun = (state == RUN) && (step == 3'd7) && !Rom_Word[26];
`endif
        end_eff = Rom_Word[26] | overrun;
    end

    assign Instr_Ready = !Reset_In && !Flush && !Stall && ((state == IDLE) || end_eff);
    assign accept      = Instr_Valid && Instr_Ready;
    assign Rom_Addr    = {opcode_reg, step};

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state      <= IDLE;
            step       <= 3'd0;
            opcode_reg <= 8'd0;
            ctrl_q     <= NOP;
            vld_q      <= 1'b0;
        end else if (Flush) begin
            state  <= IDLE;
            step   <= 3'd0;
            ctrl_q <= NOP;
            vld_q  <= 1'b0;
        end else if (!Stall) begin
            case (state)
                IDLE: begin
                    ctrl_q <= NOP;
                    vld_q  <= 1'b0;
                    if (accept) begin
                        opcode_reg <= Instr_Opcode;
                        step       <= 3'd0;
                        state      <= RUN;
                    end
                end
                default: begin
                    ctrl_q <= Rom_Word[25:0];
                    vld_q  <= 1'b1;
                    if (!end_eff) begin
                        step <= step + 3'd1;
                    end else if (accept) begin
                        // Last word of this instruction and the next accept share the edge.
                        opcode_reg <= Instr_Opcode;
                        step       <= 3'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef BUS_CTRL_PIPE_STEP_LIMIT_EN
    logic ovf_q;
    always_ff @(posedge Clock_In) begin
        if (Reset_In)
            ovf_q <= 1'b0;
        else if (!Flush && !Stall && overrun)
            ovf_q <= 1'b1;
    end
    assign Step_Overflow = ovf_q;
`else
    assign Step_Overflow = 1'b0;
`endif

    assign Bus_Assert  = ctrl_q[3:0];
    assign Bus_Load    = ctrl_q[7:4];
    assign Xfer_Assert = ctrl_q[10:8];
    assign XferLoadDec = ctrl_q[14:11];
    assign Inc_PCRA    = ctrl_q[16:15];
    assign Inc_SPSIDI  = ctrl_q[18:17];
    assign LHS         = ctrl_q[20:19];
    assign RHS         = ctrl_q[22:21];
    assign AddrSel     = ctrl_q[25:23];
    assign Ctrl_Valid  = vld_q;

endmodule
